conv_col_driver: RTL and testbench
==================================

CONV_COL_DRIVER -- requirements
Module: conv_col_driver

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels (legal range 2 or more).
REQ-002 SHALL have parameter IMG_H, default 64, image height in rows (legal range 3 or more).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port pix_vld_i  input  1  raster input pixel valid.
REQ-007 SHALL have port pix_dat_i  input  conv_pkg::PIXEL_W  raster input pixel.
REQ-008 SHALL have port pix_rdy_o  output  1  input ready; a pixel is accepted when pix_vld_i and pix_rdy_o are both 1.
REQ-009 SHALL have port colD_push_o  output  5  per-row valid mask of the emitted column.
REQ-010 SHALL have port colD_dat_o  output  conv_pkg::pixel_span_t  five pixels, index n = row offset n-2 from the centre row.
REQ-011 SHALL have port colD_pos_o  output  conv_pkg::kernel_pos_t  flags sol, eol, sof, eof of the centre pixel.

Function
REQ-012 SHALL store the most recent 4 image rows in a circular line buffer (4 x IMG_W pixels), addressed by a column counter c and a row counter r.
REQ-013 SHALL implement FSM FILL -> STREAM -> DRAIN -> FILL.
- FILL: input rows 0-1; pixels are written only; no column is emitted.
- STREAM: input rows 2..IMG_H-1.
- DRAIN: 2*IMG_W cycles with no input.
REQ-014 SHALL, in STREAM, emit exactly one column per accepted pixel (r,c), with centre row y=r-2 and column c.
REQ-015 SHALL, in DRAIN, emit one column per cycle from the line buffer for centre rows IMG_H-2 then IMG_H-1, columns 0..IMG_W-1.
REQ-016 SHALL hold pix_rdy_o=1 in FILL and STREAM, and pix_rdy_o=0 in DRAIN.
REQ-017 SHALL enter DRAIN on the cycle after the pixel (IMG_H-1, IMG_W-1) is accepted, and SHALL return to FILL with all counters at 0 after the last drain emission.
REQ-018 SHALL register all column outputs: an emission decided in cycle t appears on the outputs in cycle t+1 and is held for one cycle only.
REQ-019 SHALL set colD_push_o[n]=1 if and only if 0 <= y-2+n < IMG_H; colD_push_o=0 in every non-emitting cycle.
REQ-020 SHALL drive colD_dat_o[n]=0 wherever colD_push_o[n]=0.
REQ-021 SHALL set the position flags as follows:
- sol=(c==0)
- eol=(c==IMG_W-1)
- sof=(y==0 && c==0)
- eof=(y==IMG_H-1 && c==IMG_W-1)
- all flags 0 when nothing is emitted.
REQ-022 SHALL provide no output backpressure; the downstream consumer accepts every column.
REQ-023 SHALL wrap c at IMG_W-1 (clearing c and incrementing r), and SHALL wrap the line-buffer row pointer modulo 4.
REQ-024 SHALL hold all state unchanged in cycles with pix_vld_i=0 outside DRAIN; input gaps SHALL only delay output.
REQ-025 SHALL ignore pix_vld_i during DRAIN.

Reset
REQ-026 SHALL, with rst=1, within the same clock edge set:
- FSM=FILL, c=0, r=0, drain counter=0
- colD_push_o=0, colD_dat_o=0, colD_pos_o=0
- pix_rdy_o=1 in the following cycle.
REQ-027 SHALL not require line-buffer contents to be cleared by reset; stale data is never visible because of REQ-019 and REQ-020.
REQ-028 SHALL, when reset occurs mid-frame (any state), abandon the partial frame; the next accepted pixel is treated as (0,0).

Verification (IMG_W=4, IMG_H=4, pixel value = r*16+c)
REQ-029 Reset: assert rst for 2 cycles -> colD_push_o=0, colD_pos_o=0, pix_rdy_o=1.
REQ-030 Fill then first column:
- stream pixels 0x00..0x13 back-to-back -> no push.
- accept 0x20 -> next cycle: push=5'b11100, dat[2..4]=0x00,0x10,0x20, dat[0..1]=0, sol=1, sof=1.
REQ-031 Stream end and drain:
- accept 0x33 -> next cycle: push=5'b11110, centre y=1, eol=1.
- pix_rdy_o=0 for exactly 8 cycles.
- drain columns: y=2 with push=5'b01111, then y=3 with push=5'b00111.
- last column dat[0..2]=0x13,0x23,0x33 with eol=1, eof=1.
- then pix_rdy_o=1.
REQ-032 Input gaps: drop pix_vld_i for 3 cycles mid row 2 -> no push in the corresponding cycles; column sequence and values identical to the gap-free run.
REQ-033 Reset mid-DRAIN (4th drain cycle):
- push=0 next cycle, pix_rdy_o=1.
- a new full frame produces the same outputs as REQ-030 and REQ-031.
REQ-034 Back-to-back frames: second frame starts the cycle pix_rdy_o returns to 1 -> its first column appears with sof=1 and push=5'b11100; no column is lost or duplicated.

Source files
------------

// File: rtl/conv_col_driver.sv
// Column driver for a 5-row convolution window: buffers the last four raster
// rows and emits one masked, position-tagged 5-pixel column per output cycle.
package conv_pkg;
  localparam int PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [4:0] pixel_span_t;
  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } kernel_pos_t;
endpackage

module conv_col_driver #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_vld_i,
  input  logic [conv_pkg::PIXEL_W-1:0]  pix_dat_i,
  output logic                          pix_rdy_o,
  output logic [4:0]                    colD_push_o,
  output conv_pkg::pixel_span_t         colD_dat_o,
  output conv_pkg::kernel_pos_t         colD_pos_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(2 * IMG_W);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [DW-1:0] D_HALF = DW'(IMG_W);
  localparam logic [DW-1:0] D_LAST = DW'(2 * IMG_W - 1);

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_DRAIN} state_t;

  state_t                          state_reg, state_next;
  logic [CW-1:0]                   c_reg, c_next;
  logic [RW-1:0]                   r_reg, r_next;
  logic [DW-1:0]                   drain_reg, drain_next;
  logic                            accept;
  logic                            emit;
  logic                            c_last;
  int                              y_cen;
  logic [4:0]                      push_next, push_reg;
  logic [3:0][1:0]                 bank_next, bank_reg;
  conv_pkg::kernel_pos_t           pos_next, pos_reg;
  logic [conv_pkg::PIXEL_W-1:0]    pix_reg;
  logic [3:0][conv_pkg::PIXEL_W-1:0] rd_all;

  assign pix_rdy_o = (state_reg != S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FILL;
      c_reg     <= '0;
      r_reg     <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      r_reg     <= r_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    r_next     = r_reg;
    drain_next = drain_reg;
    emit       = 1'b0;
    y_cen      = 0;
    c_last     = (c_reg == C_LAST);
    accept     = pix_vld_i && (state_reg != S_DRAIN);
    case (state_reg)
      S_FILL: begin
        if (accept) begin
          if (c_last) begin
            c_next = '0;
            r_next = r_reg + 1'b1;
            if (r_reg == R_ONE) state_next = S_STREAM;
          end else begin
            c_next = c_reg + 1'b1;
          end
        end
      end
      S_STREAM: begin
        y_cen = int'(r_reg) - 2;
        if (accept) begin
          emit = 1'b1;
          if (c_last) begin
            c_next = '0;
            if (r_reg == R_LAST) begin
              r_next     = '0;
              state_next = S_DRAIN;
            end else begin
              r_next = r_reg + 1'b1;
            end
          end else begin
            c_next = c_reg + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // first half of the drain finishes row IMG_H-2, second half IMG_H-1
        emit       = 1'b1;
        y_cen      = (drain_reg >= D_HALF) ? IMG_H - 1 : IMG_H - 2;
        c_next     = c_last ? '0 : c_reg + 1'b1;
        drain_next = drain_reg + 1'b1;
        if (drain_reg == D_LAST) begin
          drain_next = '0;
          c_next     = '0;
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // Row y-2+n lives in bank (y-2+n) mod 4; rows outside the frame are masked.
  always_comb begin
    push_next = '0;
    bank_next = '0;
    for (int n = 0; n < 5; n++) begin
      push_next[n] = emit && (y_cen - 2 + n >= 0) && (y_cen - 2 + n < IMG_H);
    end
    for (int n = 0; n < 4; n++) begin
      bank_next[n] = 2'(y_cen - 2 + n);
    end
    pos_next.sol = emit && (c_reg == '0);
    pos_next.eol = emit && c_last;
    pos_next.sof = emit && (y_cen == 0) && (c_reg == '0);
    pos_next.eof = emit && (y_cen == IMG_H - 1) && c_last;
  end

  // Read-before-write: while row r overwrites its bank, the old row r-4 is read out.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [conv_pkg::PIXEL_W-1:0] mem [IMG_W];
      logic [conv_pkg::PIXEL_W-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (accept && (r_reg[1:0] == 2'(gi))) mem[c_reg] <= pix_dat_i;
        rd_q <= mem[c_reg];
      end
      assign rd_all[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      push_reg <= '0;
      bank_reg <= '0;
      pos_reg  <= '0;
      pix_reg  <= '0;
    end else begin
      push_reg <= push_next;
      bank_reg <= bank_next;
      pos_reg  <= pos_next;
      pix_reg  <= pix_dat_i;
    end
  end

  always_comb begin
    colD_dat_o = '0;
    for (int n = 0; n < 4; n++) begin
      if (push_reg[n]) colD_dat_o[n] = rd_all[bank_reg[n]];
    end
    if (push_reg[4]) colD_dat_o[4] = pix_reg;
  end

  assign colD_push_o = push_reg;
  assign colD_pos_o  = pos_reg;

endmodule

// File: tb/tb_conv_col_driver.sv
// Directed bench for conv_col_driver (4x4 image, pixel = r*16+c) with a
// cycle-stamped scoreboard of expected columns.
module tb_conv_col_driver;
  import conv_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pix_vld_i = 1'b0;
  logic [PIXEL_W-1:0]  pix_dat_i = '0;
  logic                pix_rdy_o;
  logic [4:0]          colD_push_o;
  pixel_span_t         colD_dat_o;
  kernel_pos_t         colD_pos_o;

  conv_col_driver #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_vld_i   (pix_vld_i),
    .pix_dat_i   (pix_dat_i),
    .pix_rdy_o   (pix_rdy_o),
    .colD_push_o (colD_push_o),
    .colD_dat_o  (colD_dat_o),
    .colD_pos_o  (colD_pos_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  push;
    pixel_span_t dat;
    kernel_pos_t pos;
    int          due;
    int          y;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mr = 0;
  int mc = 0;
  int rdy_low = 0;
  int pops = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input int y, input int c, input int due);
    exp_t e;
    int row;
    e.push = '0;
    e.dat  = '0;
    for (int n = 0; n < 5; n++) begin
      row = y - 2 + n;
      if (row >= 0 && row < H) begin
        e.push[n] = 1'b1;
        e.dat[n]  = PIXEL_W'(row * 16 + c);
      end
    end
    e.pos.sol = (c == 0);
    e.pos.eol = (c == W - 1);
    e.pos.sof = (y == 0) && (c == 0);
    e.pos.eof = (y == H - 1) && (c == W - 1);
    e.due = due;
    e.y   = y;
    e.c   = c;
    return e;
  endfunction

  task automatic model_accept();
    if (mr >= 2) exp_q.push_back(mk(mr - 2, mc, cyc));
    if (mr == H - 1 && mc == W - 1) begin
      for (int i = 0; i < 2 * W; i++) exp_q.push_back(mk(H - 2 + i / W, i % W, cyc + 1 + i));
      mr = 0;
      mc = 0;
    end else if (mc == W - 1) begin
      mc = 0;
      mr++;
    end else begin
      mc++;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (colD_push_o !== 5'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_col", 64'(colD_push_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        pops++;
        $display("col cyc=%0d y=%0d c=%0d push=%b dat=%h pos=%b", cyc, e.y, e.c,
                 colD_push_o, colD_dat_o, colD_pos_o);
        chk("col_cycle", 64'(cyc), 64'(e.due));
        chk("col_push", 64'(colD_push_o), 64'(e.push));
        chk("col_dat", 64'(colD_dat_o), 64'(e.dat));
        chk("col_pos", 64'(colD_pos_o), 64'(e.pos));
      end
    end else begin
      chk("idle_dat", 64'(colD_dat_o), 64'd0);
      chk("idle_pos", 64'(colD_pos_o), 64'd0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("missing_col_push", 64'(colD_push_o), 64'(exp_q[0].push));
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    logic acc;
    logic rs;
    acc = pix_vld_i && pix_rdy_o && !rst;
    rs  = rst;
    @(posedge clk);
    cyc++;
    if (rs) begin
      exp_q.delete();
      mr = 0;
      mc = 0;
    end
    if (acc) model_accept();
    #1;
    check_outputs();
    if (pix_rdy_o === 1'b0) rdy_low++;
  endtask

  task automatic send_pixel(input int r, input int c);
    logic a;
    bit done;
    done = 0;
    pix_vld_i = 1'b1;
    pix_dat_i = PIXEL_W'(r * 16 + c);
    for (int k = 0; k < 50 && !done; k++) begin
      a = pix_rdy_o;
      tick();
      if (a === 1'b1) done = 1;
    end
    if (!done) chk("accept_timeout_rdy", 64'(pix_rdy_o), 64'd1);
  endtask

  task automatic send_frame(input int gap_r, input int gap_c);
    rdy_low = 0;
    pops = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == gap_r && c == gap_c) begin
          pix_vld_i = 1'b0;
          pix_dat_i = 8'hAA;
          repeat (3) tick();
        end
        send_pixel(r, c);
      end
    end
    pix_vld_i = 1'b0;
  endtask

  task automatic wait_drain(input bit junk);
    bit done;
    done = 0;
    if (junk) begin
      pix_vld_i = 1'b1;
      pix_dat_i = 8'hEE;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      if (pix_rdy_o === 1'b1) done = 1;
      else tick();
    end
    pix_vld_i = 1'b0;
    chk("drain_rdy_low_cycles", 64'(rdy_low), 64'd8);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_columns", 64'(pops), 64'(W * H));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_push", 64'(colD_push_o), 64'd0);
    chk("reset_pos", 64'(colD_pos_o), 64'd0);
    chk("reset_rdy", 64'(pix_rdy_o), 64'd1);

    // plain frame, junk valid held high during drain
    send_frame(-1, -1);
    wait_drain(1'b1);

    // back-to-back frame with a 3-cycle input gap in row 2
    send_frame(2, 1);
    wait_drain(1'b0);

    // reset on the 4th drain cycle
    send_frame(-1, -1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("middrain_rst_push", 64'(colD_push_o), 64'd0);
    chk("middrain_rst_rdy", 64'(pix_rdy_o), 64'd1);
    tick();

    send_frame(-1, -1);
    wait_drain(1'b0);
    repeat (3) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=done", cyc);
    $fatal(1, "watchdog");
  end

endmodule
